bottle_fill_ctrl: RTL and testbench

Per-bottle fill controller. It consumes the BCD per-bottle limit `maxH`:`maxL` produced by the limit-setting stage. It counts debounced-free pill sensor edges into the current bottle, closes the feed gate and pulses `done` when the limit is reached, and runs a bottle-swap handshake before starting the next bottle. It also keeps a two-digit BCD count of finished bottles for the display stage.

---
 rtl/bottle_fill_ctrl.sv | 147 ++++++++++++++
 tb/tb_bottle_fill_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bottle_fill_ctrl.sv
// Per-bottle pill fill controller: counts synchronised pill edges up to a
// latched BCD limit, runs the bottle swap handshake and counts finished bottles.
module bottle_fill_ctrl (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       EN_work,
    input  logic       EN_set,
    input  logic [3:0] maxL,
    input  logic [3:0] maxH,
    input  logic       pill_in,
    input  logic       bottle_ready,
    input  logic       clr,
    output logic       gate_open,
    output logic       full,
    output logic       done,
    output logic       err,
    output logic [3:0] cntL,
    output logic [3:0] cntH,
    output logic [3:0] botL,
    output logic [3:0] botH
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_EMPTY = 2'd3;

    logic [1:0] r_state;
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [3:0] r_limL;
    logic [3:0] r_limH;
    logic [3:0] r_cntL;
    logic [3:0] r_cntH;
    logic [3:0] r_botL;
    logic [3:0] r_botH;
    logic       r_done;
    logic       r_err;

    logic       w_pulse;
    logic       w_run;
    logic       w_start;
    logic [3:0] w_inL;
    logic [3:0] w_inH;
    logic [3:0] w_cnt_nL;
    logic [3:0] w_cnt_nH;
    logic [3:0] w_bot_nL;
    logic [3:0] w_bot_nH;
    logic       w_hit;

    assign w_pulse = r_s2 & ~r_s3;
    assign w_run   = EN_work & ~EN_set;
    assign w_start = w_run & bottle_ready & ({maxH, maxL} != 8'h00);

    // Out-of-range digits are clamped so the limit is always reachable.
    assign w_inL = (maxL > 4'd9) ? 4'd9 : maxL;
    assign w_inH = (maxH > 4'd9) ? 4'd9 : maxH;

    assign w_cnt_nL = (r_cntL == 4'd9) ? 4'd0 : r_cntL + 4'd1;
    assign w_cnt_nH = (r_cntL != 4'd9) ? r_cntH :
                      (r_cntH == 4'd9) ? 4'd0 : r_cntH + 4'd1;
    assign w_bot_nL = (r_botL == 4'd9) ? 4'd0 : r_botL + 4'd1;
    assign w_bot_nH = (r_botL != 4'd9) ? r_botH :
                      (r_botH == 4'd9) ? 4'd0 : r_botH + 4'd1;
    assign w_hit    = ({w_cnt_nH, w_cnt_nL} == {r_limH, r_limL});

    assign gate_open = (r_state == S_FILL) & w_run;
    assign full      = (r_state == S_FULL);
    assign done      = r_done;
    assign err       = r_err;
    assign cntL      = r_cntL;
    assign cntH      = r_cntH;
    assign botL      = r_botL;
    assign botH      = r_botH;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pill_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
            r_limL  <= 4'd0;
            r_limH  <= 4'd0;
            r_cntL  <= 4'd0;
            r_cntH  <= 4'd0;
            r_botL  <= 4'd0;
            r_botH  <= 4'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (clr) begin
            r_state <= S_IDLE;
            r_cntL  <= 4'd0;
            r_cntH  <= 4'd0;
            r_botL  <= 4'd0;
            r_botH  <= 4'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_EMPTY: begin
                    if (w_pulse && r_state == S_EMPTY) begin
                        r_err <= 1'b1;
                    end
                    if (w_start) begin
                        r_state <= S_FILL;
                        r_cntL  <= 4'd0;
                        r_cntH  <= 4'd0;
                        r_limL  <= w_inL;
                        r_limH  <= w_inH;
                    end
                end
                S_FILL: begin
                    if (w_pulse && w_run) begin
                        r_cntL <= w_cnt_nL;
                        r_cntH <= w_cnt_nH;
                        if (w_hit) begin
                            r_state <= S_FULL;
                            r_done  <= 1'b1;
                            r_botL  <= w_bot_nL;
                            r_botH  <= w_bot_nH;
                        end
                    end
                end
                default: begin
                    if (w_pulse) begin
                        r_err <= 1'b1;
                    end
                    if (!bottle_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed testbench for bottle_fill_ctrl with immediate-assertion checks.
module tb_bottle_fill_ctrl;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       EN_work;
    logic       EN_set;
    logic [3:0] maxL;
    logic [3:0] maxH;
    logic       pill_in;
    logic       bottle_ready;
    logic       clr;
    logic       gate_open;
    logic       full;
    logic       done;
    logic       err;
    logic [3:0] cntL;
    logic [3:0] cntH;
    logic [3:0] botL;
    logic [3:0] botH;

    int checks   = 0;
    int failures = 0;
    logic d;

    bottle_fill_ctrl dut (
        .CLK(CLK), .RST_n(RST_n), .EN_work(EN_work), .EN_set(EN_set),
        .maxL(maxL), .maxH(maxH), .pill_in(pill_in),
        .bottle_ready(bottle_ready), .clr(clr),
        .gate_open(gate_open), .full(full), .done(done), .err(err),
        .cntL(cntL), .cntH(cntH), .botL(botL), .botH(botH)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One pill, high 2 cycles; dn = done right after the counting edge.
    task automatic pill(output logic dn);
        pill_in = 1'b1;
        tick();
        tick();
        pill_in = 1'b0;
        tick();
        dn = done;
        tick();
    endtask

    initial begin
        RST_n = 1'b0; EN_work = 1'b0; EN_set = 1'b0;
        maxL = 4'd0; maxH = 4'd0; pill_in = 1'b0;
        bottle_ready = 1'b0; clr = 1'b0;
        tick();
        chk1("rst_gate", gate_open, 1'b0);
        chk1("rst_full", full, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk8("rst_cnt", {cntH, cntL}, 8'h00);
        chk8("rst_bot", {botH, botL}, 8'h00);
        RST_n = 1'b1;
        tick();

        // basic fill, limit 05
        EN_work = 1'b1; maxH = 4'd0; maxL = 4'd5; bottle_ready = 1'b1;
        tick();
        chk1("fill_gate", gate_open, 1'b1);
        chk8("fill_cnt0", {cntH, cntL}, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            pill(d);
            chk8("basic_cnt", {cntH, cntL}, 8'(i));
            chk1("basic_done", d, (i == 5));
        end
        chk1("basic_done_1cyc", done, 1'b0);
        chk1("basic_full", full, 1'b1);
        chk1("basic_gate", gate_open, 1'b0);
        chk8("basic_bot", {botH, botL}, 8'h01);

        // swap handshake
        pill(d);
        chk1("swap_err", err, 1'b1);
        chk8("swap_cnt_hold", {cntH, cntL}, 8'h05);
        bottle_ready = 1'b0;
        tick();
        chk1("empty_full", full, 1'b0);
        chk8("empty_cnt", {cntH, cntL}, 8'h05);
        maxL = 4'd3; bottle_ready = 1'b1;
        tick();
        chk8("swap_cnt0", {cntH, cntL}, 8'h00);
        chk1("swap_gate", gate_open, 1'b1);
        pill(d); chk1("swap_d1", d, 1'b0);
        pill(d); chk1("swap_d2", d, 1'b0);
        pill(d); chk1("swap_d3", d, 1'b1);
        chk8("swap_bot", {botH, botL}, 8'h02);
        chk1("swap_err_sticky", err, 1'b1);

        // clr, then limit 12 with BCD carry
        clr = 1'b1;
        tick();
        chk1("clr_err", err, 1'b0);
        chk8("clr_bot", {botH, botL}, 8'h00);
        chk8("clr_cnt", {cntH, cntL}, 8'h00);
        chk1("clr_full", full, 1'b0);
        clr = 1'b0; maxH = 4'd1; maxL = 4'd2;
        tick();
        for (int i = 1; i <= 12; i++) begin
            pill(d);
            if (i == 9) chk8("carry_09", {cntH, cntL}, 8'h09);
            if (i == 10) chk8("carry_10", {cntH, cntL}, 8'h10);
            chk1("carry_done", d, (i == 12));
        end
        chk8("carry_12", {cntH, cntL}, 8'h12);
        chk8("carry_bot", {botH, botL}, 8'h01);

        // pause mid-fill, limit change applies only to next bottle
        bottle_ready = 1'b0;
        tick();
        maxH = 4'd0; maxL = 4'd4; bottle_ready = 1'b1;
        tick();
        pill(d);
        pill(d);
        chk8("pause_cnt2", {cntH, cntL}, 8'h02);
        EN_set = 1'b1; maxL = 4'd9;
        #1;
        chk1("pause_gate", gate_open, 1'b0);
        pill(d);
        pill(d);
        chk8("pause_hold", {cntH, cntL}, 8'h02);
        chk1("pause_noerr", err, 1'b0);
        EN_set = 1'b0;
        pill(d); chk1("pause_d3", d, 1'b0);
        pill(d); chk1("pause_d4", d, 1'b1);
        chk8("pause_cnt4", {cntH, cntL}, 8'h04);
        chk8("pause_bot", {botH, botL}, 8'h02);

        // limit 00 never starts
        bottle_ready = 1'b0;
        tick();
        maxL = 4'd0; bottle_ready = 1'b1;
        tick(); tick(); tick();
        chk1("lim00_gate", gate_open, 1'b0);
        chk1("lim00_full", full, 1'b0);
        chk8("lim00_cnt", {cntH, cntL}, 8'h04);

        // reach bot=03, then clr at cnt=07
        maxL = 4'd1;
        tick();
        pill(d);
        chk1("one_done", d, 1'b1);
        bottle_ready = 1'b0;
        tick();
        maxL = 4'd9; bottle_ready = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) pill(d);
        chk8("pre_clr_cnt", {cntH, cntL}, 8'h07);
        chk8("pre_clr_bot", {botH, botL}, 8'h03);
        clr = 1'b1; bottle_ready = 1'b0;
        tick();
        clr = 1'b0;
        chk8("clrf_cnt", {cntH, cntL}, 8'h00);
        chk8("clrf_bot", {botH, botL}, 8'h00);
        chk1("clrf_gate", gate_open, 1'b0);
        chk1("clrf_err", err, 1'b0);

        // bottle counter wrap 99 -> 00
        maxL = 4'd1;
        for (int i = 0; i < 99; i++) begin
            bottle_ready = 1'b1;
            tick();
            pill(d);
            bottle_ready = 1'b0;
            tick();
        end
        chk8("wrap_99", {botH, botL}, 8'h99);
        bottle_ready = 1'b1;
        tick();
        pill(d);
        chk1("wrap_done", d, 1'b1);
        chk8("wrap_00", {botH, botL}, 8'h00);

        // async reset mid-fill
        bottle_ready = 1'b0;
        tick();
        maxL = 4'd5; bottle_ready = 1'b1;
        tick();
        pill(d);
        pill(d);
        chk8("ar_pre_cnt", {cntH, cntL}, 8'h02);
        chk1("ar_pre_gate", gate_open, 1'b1);
        #2;
        RST_n = 1'b0;
        #1;
        chk1("ar_gate", gate_open, 1'b0);
        chk8("ar_cnt", {cntH, cntL}, 8'h00);
        chk8("ar_bot", {botH, botL}, 8'h00);
        chk1("ar_full", full, 1'b0);
        tick();
        RST_n = 1'b1; bottle_ready = 1'b0;
        tick();
        chk1("ar_idle_gate", gate_open, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
